// File: rtl/fp32_accum_ctrl.sv
// -----------------------------------------------------------------------------
// fp32_accum_ctrl
//   Sequential wrapper around an external combinational fp32 adder. Accepts a
//   stream of `len` fp32 operands over a valid/ready handshake, accumulates
//   them as acc <= acc + operand, presents the final sum on a valid/ready
//   output and keeps sticky NaN / infinity flags for the current reduction.
//
// Optional feature macro: FP32_ACC_PIPE_EN
//   When defined, the operand is registered (b_q) on its handshake and the
//   adder result is consumed one cycle later in a WAIT state, giving one
//   operand every two clocks.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a reduction (only honoured in IDLE)
//   len        in   operand count, sampled with start
//   in_valid   in   operand valid
//   in_data    in   fp32 operand
//   in_ready   out  operand accepted on in_valid & in_ready
//   add_a      out  adder operand a (running sum)
//   add_b      out  adder operand b (operand, or captured operand when piped)
//   add_sum    in   adder result
//   out_valid  out  final sum valid
//   out_data   out  final sum
//   out_ready  in   consumer ready
//   busy       out  high whenever not IDLE
//   exc_nan    out  sticky: a captured sum was NaN
//   exc_inf    out  sticky: a captured sum was +/-inf
// -----------------------------------------------------------------------------
module fp32_accum_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             exc_nan,
    output logic             exc_inf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // NaN: all-ones exponent with a non-zero mantissa
    function automatic logic f_is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Infinity: all-ones exponent with a zero mantissa
    function automatic logic f_is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [31:0]      acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] len_q_r;
    logic             exc_nan_r;
    logic             exc_inf_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             hs_in_s;
    logic             hs_out_s;
    logic             last_s;

`ifdef FP32_ACC_PIPE_EN
    logic [31:0]      b_q_r;
`endif

    assign hs_in_s  = in_valid & in_ready_r;
    assign hs_out_s = out_valid_r & out_ready;
    // cnt_r < len_q_r whenever an operand is in flight, so +1 cannot wrap
    assign last_s   = ((cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) == len_q_r);

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len != {CNT_W{1'b0}}) begin
                        state_nxt_s = ST_ACCUM;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (hs_in_s) begin
`ifdef FP32_ACC_PIPE_EN
                    state_nxt_s = ST_WAIT;
`else
                    if (last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
`endif
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_WAIT: begin
`ifdef FP32_ACC_PIPE_EN
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
`else
                state_nxt_s = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (hs_out_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and handshake outputs, registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_ACCUM);
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Accumulator, element counter, length latch and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r     <= 32'h0000_0000;
            cnt_r     <= {CNT_W{1'b0}};
            len_q_r   <= {CNT_W{1'b0}};
            exc_nan_r <= 1'b0;
            exc_inf_r <= 1'b0;
`ifdef FP32_ACC_PIPE_EN
            b_q_r     <= 32'h0000_0000;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r     <= 32'h0000_0000;
                        cnt_r     <= {CNT_W{1'b0}};
                        exc_nan_r <= 1'b0;
                        exc_inf_r <= 1'b0;
                        if (len != {CNT_W{1'b0}}) begin
                            len_q_r <= len;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (hs_in_s) begin
`ifdef FP32_ACC_PIPE_EN
                        b_q_r     <= in_data;
`else
                        acc_r     <= add_sum;
                        cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        exc_nan_r <= exc_nan_r | f_is_nan(add_sum);
                        exc_inf_r <= exc_inf_r | f_is_inf(add_sum);
`endif
                    end
                end
                ST_WAIT: begin
`ifdef FP32_ACC_PIPE_EN
                    // Adder saw {acc, b_q} during this whole cycle
                    acc_r     <= add_sum;
                    cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    exc_nan_r <= exc_nan_r | f_is_nan(add_sum);
                    exc_inf_r <= exc_inf_r | f_is_inf(add_sum);
`endif
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = acc_r;
    assign busy      = busy_r;
    assign exc_nan   = exc_nan_r;
    assign exc_inf   = exc_inf_r;
    assign add_a     = acc_r;
`ifdef FP32_ACC_PIPE_EN
    assign add_b     = b_q_r;
`else
    assign add_b     = in_data;
`endif

endmodule

// File: tb/tb_fp32_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fp32_accum_ctrl
//   Directed self-checking bench for fp32_accum_ctrl. The external adder is a
//   lookup table of the exact operand pairs used here; unknown pairs yield a
//   NaN so that a wrongly sequenced datapath shows up in results and flags.
// -----------------------------------------------------------------------------
module tb_fp32_accum_ctrl;

    localparam int CNT_W = 8;
`ifdef FP32_ACC_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;
    logic             busy;
    logic             exc_nan;
    logic             exc_inf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp32_accum_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .exc_nan(exc_nan), .exc_inf(exc_inf)
    );

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] k;
        k = {a, b};
        case (k)
            {32'h0000_0000, 32'h3F80_0000}: return 32'h3F80_0000; // 0 + 1 = 1
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000; // 1 + 2 = 3
            {32'h4040_0000, 32'h4040_0000}: return 32'h40C0_0000; // 3 + 3 = 6
            {32'h3F80_0000, 32'hBF80_0000}: return 32'h0000_0000; // 1 - 1 = +0
            {32'h0000_0000, 32'h7F80_0000}: return 32'h7F80_0000; // 0 + inf
            {32'h7F80_0000, 32'hFF80_0000}: return 32'h7FC0_0000; // inf - inf = NaN
            {32'h0000_0000, 32'h4000_0000}: return 32'h4000_0000; // 0 + 2 = 2
            default:                        return 32'h7FFF_FFFF;
        endcase
    endfunction

    always_comb add_sum = fp_add(add_a, add_b);

    task automatic do_start(input logic [CNT_W-1:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_op(input logic [31:0] d);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_op_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int maxc, output int waited);
        waited = 0;
        while (!out_valid && waited < maxc) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_out_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (add_a !== 32'h0000_0000) begin n_fail++; $display("FAIL reset_acc: got %h want 00000000", add_a); end
        n_checks++; if ({exc_nan, exc_inf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {exc_nan, exc_inf}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_sum();
        int w;
        do_start(8'd3);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
`ifndef FP32_ACC_PIPE_EN
        in_data = 32'h3F80_0000;
        #1;
        n_checks++; if (add_b !== 32'h3F80_0000) begin n_fail++; $display("FAIL basic_add_b: got %h want 3f800000", add_b); end
`endif
        send_op(32'h3F80_0000);
        send_op(32'h4000_0000);
        send_op(32'h4040_0000);
        wait_out(6, w);
        n_checks++; if (w !== EXTRA) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", w, EXTRA); end
        n_checks++; if (out_data !== 32'h40C0_0000) begin n_fail++; $display("FAIL basic_out_data: got %h want 40c00000", out_data); end
        n_checks++; if ({exc_nan, exc_inf} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b want 00", {exc_nan, exc_inf}); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_done_in_ready: got %b want 0", in_ready); end
        drain();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_len_zero();
        do_start(8'd0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL len0_out_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 32'h0000_0000) begin n_fail++; $display("FAIL len0_out_data: got %h want 00000000", out_data); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL len0_in_ready: got %b want 0", in_ready); end
        drain();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_idle: got %b want 0", busy); end
    endtask

    task automatic test_gaps();
        int w;
        do_start(8'd2);
        send_op(32'h3F80_0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (add_a !== 32'h3F80_0000) begin n_fail++; $display("FAIL gap_acc_hold[%0d]: got %h want 3f800000", i, add_a); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_not_done[%0d]: got %b want 0", i, out_valid); end
        end
        send_op(32'hBF80_0000);
        wait_out(6, w);
        n_checks++; if (out_data !== 32'h0000_0000) begin n_fail++; $display("FAIL gap_out_data: got %h want 00000000", out_data); end
        n_checks++; if ({exc_nan, exc_inf} !== 2'b00) begin n_fail++; $display("FAIL gap_flags: got %b want 00", {exc_nan, exc_inf}); end
        drain();
    endtask

    task automatic test_exceptions();
        int w;
        do_start(8'd2);
        send_op(32'h7F80_0000);
        send_op(32'hFF80_0000);
        wait_out(6, w);
        n_checks++; if (out_data !== 32'h7FC0_0000) begin n_fail++; $display("FAIL exc_out_data: got %h want 7fc00000", out_data); end
        n_checks++; if (exc_nan !== 1'b1) begin n_fail++; $display("FAIL exc_nan_set: got %b want 1", exc_nan); end
        n_checks++; if (exc_inf !== 1'b1) begin n_fail++; $display("FAIL exc_inf_set: got %b want 1", exc_inf); end
        drain();
        n_checks++; if (exc_nan !== 1'b1) begin n_fail++; $display("FAIL exc_nan_sticky_idle: got %b want 1", exc_nan); end
        do_start(8'd1);
        n_checks++; if ({exc_nan, exc_inf} !== 2'b00) begin n_fail++; $display("FAIL exc_clear_on_start: got %b want 00", {exc_nan, exc_inf}); end
        send_op(32'h3F80_0000);
        wait_out(6, w);
        n_checks++; if (out_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL exc_rerun_data: got %h want 3f800000", out_data); end
        n_checks++; if ({exc_nan, exc_inf} !== 2'b00) begin n_fail++; $display("FAIL exc_rerun_flags: got %b want 00", {exc_nan, exc_inf}); end
        drain();
    endtask

    task automatic test_output_stall();
        int w;
        do_start(8'd1);
        send_op(32'h4000_0000);
        wait_out(6, w);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd3;
            @(posedge clk); #1;
            start = 1'b0;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_data !== 32'h4000_0000) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want 40000000", i, out_data); end
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_release_busy: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_start_ignored: got %b want 0", in_ready); end
    endtask

    task automatic test_mid_reset();
        int w;
        do_start(8'd4);
        send_op(32'h3F80_0000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (add_a !== 32'h0000_0000) begin n_fail++; $display("FAIL midrst_acc: got %h want 00000000", add_a); end
        do_start(8'd1);
        send_op(32'h4000_0000);
        wait_out(6, w);
        n_checks++; if (out_data !== 32'h4000_0000) begin n_fail++; $display("FAIL midrst_rerun_data: got %h want 40000000", out_data); end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 32'h0000_0000;
        out_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_len_zero();
        test_gaps();
        test_exceptions();
        test_output_stall();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
